// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel streaming path: image geometry defaults,
// pixel width, frame-source state encoding and the FIFO beat layout.
package sobel_pkg;

  localparam int IMG_X_SIZE = 320;
  localparam int IMG_Y_SIZE = 240;
  localparam int PIX_W      = 8;
  localparam int N_PIX      = IMG_X_SIZE * IMG_Y_SIZE;
  localparam int BEAT_W     = PIX_W + 2;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  typedef struct packed {
    logic             eop;
    logic             sop;
    logic [PIX_W-1:0] data;
  } beat_t;

  function automatic logic is_busy(input logic [1:0] st);
    return (st == STREAM) || (st == DRAIN);
  endfunction

endpackage

// File: rtl/st_skid_fifo.sv
// Four-entry synchronous FIFO with count/empty/full, used as the output
// skid buffer of Avalon-ST sources. The head entry is always presented.
module st_skid_fifo #(
  parameter int W = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic [2:0]   count_o,
  output logic         empty_o,
  output logic         full_o
);

  logic [W-1:0] mem_q [4];
  logic [1:0]   wr_ptr_q, wr_ptr_d;
  logic [1:0]   rd_ptr_q, rd_ptr_d;
  logic [2:0]   count_q,  count_d;
  logic         empty_s, full_s, do_push_s, do_pop_s;

  assign empty_s = (count_q == 3'd0);
  assign full_s  = (count_q == 3'd4);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push_s = push_i & (~full_s | pop_i);
  assign do_pop_s  = pop_i & ~empty_s;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + 2'd1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= {W{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= wdata_i;
      end
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = empty_s;
  assign full_o  = full_s;

  st_skid_fifo_chk u_chk (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_i),
    .full_i  (full_s),
    .count_i (count_q)
  );

endmodule

// File: rtl/st_skid_fifo_chk.sv
// Simulation-only protocol checks for st_skid_fifo: no push into a full
// FIFO and the occupancy never exceeds the depth.
module st_skid_fifo_chk (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic       full_i,
  input  logic [2:0] count_i
);

  a_no_push_when_full: assert property (
    @(posedge clk_i) disable iff (rst_i) !(push_i && full_i)
  );

  a_count_in_range: assert property (
    @(posedge clk_i) disable iff (rst_i) (count_i <= 3'd4)
  );

endmodule

// File: rtl/avalon_st_frame_source.sv
// Streams one stored grayscale frame from a synchronous frame-buffer read
// port as a single Avalon-ST packet, one pixel per beat, with backpressure.
module avalon_st_frame_source
  import sobel_pkg::*;
#(
  parameter int IMG_X_SIZE = sobel_pkg::IMG_X_SIZE,
  parameter int IMG_Y_SIZE = sobel_pkg::IMG_Y_SIZE,
  parameter int ADDR_W     = 17
) (
  input  logic              csi_clkrst_clk,
  input  logic              csi_clkrst_reset,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_rd_addr_o,
  input  logic [7:0]        mem_rd_data_i,
  input  logic              aso_source1_ready,
  output logic [7:0]        aso_source1_data,
  output logic              aso_source1_startofpacket,
  output logic              aso_source1_endofpacket,
  output logic              aso_source1_valid
);

  localparam int                N         = IMG_X_SIZE * IMG_Y_SIZE;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

  logic              clk, rst;
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              inflight_q, tag_sop_q, tag_eop_q;
  logic              busy_q, done_q;
  logic              rd_en_s, push_s, pop_s, valid_s, eop_hs_s;
  logic [2:0]        fifo_count_s;
  logic              fifo_empty_s, fifo_full_s;
  logic [BEAT_W-1:0] fifo_rdata_s;
  beat_t             push_beat_s, head_beat_s;

  assign clk = csi_clkrst_clk;
  assign rst = csi_clkrst_reset;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start_i only matters in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = STREAM;
        else         state_d = IDLE;
      end
      STREAM: begin
        if (rd_en_s && (addr_q == LAST_ADDR)) state_d = DRAIN;
        else                                  state_d = STREAM;
      end
      DRAIN: begin
        if (eop_hs_s) state_d = DONE;
        else          state_d = DRAIN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read issue and address stepping. Occupancy counts the beat still in the
  // RAM pipeline so the FIFO can never be overrun, even with ready held low.
  always_comb begin
    rd_en_s = 1'b0;
    addr_d  = addr_q;
    if ((state_q == STREAM) && !fifo_full_s &&
        (({1'b0, fifo_count_s} + {3'b000, inflight_q}) < 4'd4)) begin
      rd_en_s = 1'b1;
    end else begin
      rd_en_s = 1'b0;
    end
    if (state_q == IDLE) begin
      addr_d = {ADDR_W{1'b0}};
    end else if (rd_en_s && (addr_q != LAST_ADDR)) begin
      addr_d = addr_q + ADDR_W'(1);
    end else begin
      addr_d = addr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= {ADDR_W{1'b0}};
      inflight_q <= 1'b0;
      tag_sop_q  <= 1'b0;
      tag_eop_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      inflight_q <= rd_en_s;
      tag_sop_q  <= (addr_q == {ADDR_W{1'b0}});
      tag_eop_q  <= (addr_q == LAST_ADDR);
      busy_q     <= is_busy(state_d);
      done_q     <= (state_d == DONE);
    end
  end

  // The RAM answers one cycle after the strobe, so the tags travel with it.
  assign push_s           = inflight_q;
  assign push_beat_s.eop  = tag_eop_q;
  assign push_beat_s.sop  = tag_sop_q;
  assign push_beat_s.data = mem_rd_data_i;

  st_skid_fifo #(
    .W (BEAT_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push_s),
    .wdata_i (push_beat_s),
    .pop_i   (pop_s),
    .rdata_o (fifo_rdata_s),
    .count_o (fifo_count_s),
    .empty_o (fifo_empty_s),
    .full_o  (fifo_full_s)
  );

  assign head_beat_s = beat_t'(fifo_rdata_s);
  assign valid_s     = ~fifo_empty_s;
  assign pop_s       = valid_s & aso_source1_ready;
  assign eop_hs_s    = pop_s & head_beat_s.eop;

  assign busy_o                    = busy_q;
  assign done_o                    = done_q;
  assign mem_rd_en_o               = rd_en_s;
  assign mem_rd_addr_o             = addr_q;
  assign aso_source1_valid         = valid_s;
  assign aso_source1_data          = head_beat_s.data;
  assign aso_source1_startofpacket = head_beat_s.sop;
  assign aso_source1_endofpacket   = head_beat_s.eop;

endmodule

// File: tb/tb_avalon_st_frame_source.sv
// Scoreboard bench for avalon_st_frame_source: a 4x2 instance for the
// streaming, backpressure and reset cases and a 1x1 instance for N=1.
module tb_avalon_st_frame_source;
  import sobel_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: 4x2
  logic       rst_a, start_a, busy_a, done_a, rd_en_a, ready_a;
  logic       sop_a, eop_a, valid_a;
  logic [2:0] addr_a;
  logic [7:0] rdata_a, data_a;
  // DUT B: 1x1
  logic       rst_b, start_b, busy_b, done_b, rd_en_b, ready_b;
  logic       sop_b, eop_b, valid_b;
  logic [0:0] addr_b;
  logic [7:0] rdata_b, data_b;

  avalon_st_frame_source #(.IMG_X_SIZE(4), .IMG_Y_SIZE(2), .ADDR_W(3)) dut_a (
    .csi_clkrst_clk            (clk),
    .csi_clkrst_reset          (rst_a),
    .start_i                   (start_a),
    .busy_o                    (busy_a),
    .done_o                    (done_a),
    .mem_rd_en_o               (rd_en_a),
    .mem_rd_addr_o             (addr_a),
    .mem_rd_data_i             (rdata_a),
    .aso_source1_ready         (ready_a),
    .aso_source1_data          (data_a),
    .aso_source1_startofpacket (sop_a),
    .aso_source1_endofpacket   (eop_a),
    .aso_source1_valid         (valid_a)
  );

  avalon_st_frame_source #(.IMG_X_SIZE(1), .IMG_Y_SIZE(1), .ADDR_W(1)) dut_b (
    .csi_clkrst_clk            (clk),
    .csi_clkrst_reset          (rst_b),
    .start_i                   (start_b),
    .busy_o                    (busy_b),
    .done_o                    (done_b),
    .mem_rd_en_o               (rd_en_b),
    .mem_rd_addr_o             (addr_b),
    .mem_rd_data_i             (rdata_b),
    .aso_source1_ready         (ready_b),
    .aso_source1_data          (data_b),
    .aso_source1_startofpacket (sop_b),
    .aso_source1_endofpacket   (eop_b),
    .aso_source1_valid         (valid_b)
  );

  // Synchronous frame buffers with one cycle read latency.
  logic [7:0] mem_a [8];
  logic [7:0] mem_b0;
  always @(posedge clk) if (rd_en_a) rdata_a <= mem_a[addr_a];
  always @(posedge clk) if (rd_en_b) rdata_b <= mem_b0;

  typedef struct {
    logic [9:0] beat;   // {eop, sop, data}
    int         cyc;    // required cycle relative to start, -1 = any
  } exp_t;
  exp_t exp_q[$];

  int n_vec = 0, n_fail = 0;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  int         start_cyc = 0, mode = 0, exp_done = -1;
  int         hs_cnt = 0, done_cnt = 0, rd_idx = 0, rd_early = 0;
  bit         mon_en = 1'b0, chk_busy = 1'b0, prev_stall = 1'b0;
  logic [9:0] prev_beat = 10'd0;

  // Ready pattern: 0 always, 1 alternating from cycle 0, 2 low until 21, 3 random.
  always @(posedge clk) begin
    #2;
    case (mode)
      0:       ready_a = 1'b1;
      1:       ready_a = (((cyc - start_cyc) % 2) == 0);
      2:       ready_a = ((cyc - start_cyc) >= 21);
      default: ready_a = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor / scoreboard for DUT A.
  always @(negedge clk) begin
    int   rel;
    exp_t e;
    if (!rst_a && mon_en) begin
      rel = cyc - start_cyc;
      if (prev_stall) begin
        chk("stall_valid_held", int'(valid_a), 1);
        chk("stall_beat_stable", int'({eop_a, sop_a, data_a}), int'(prev_beat));
      end
      if (rel == 2) chk("latency_valid_low_c2", int'(valid_a), 0);
      if (rel == 3) chk("latency_valid_high_c3", int'(valid_a), 1);
      if (chk_busy && rel <= 14) chk("busy_window", int'(busy_a), int'(rel >= 1 && rel <= 10));
      if (rd_en_a) begin
        chk("rd_addr", int'(addr_a), rd_idx);
        rd_idx++;
        if (rel < 21) rd_early++;
      end
      if (valid_a && ready_a) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", int'(data_a), int'(e.beat[7:0]));
          chk("beat_sop", int'(sop_a), int'(e.beat[8]));
          chk("beat_eop", int'(eop_a), int'(e.beat[9]));
          if (e.cyc >= 0) chk("beat_cycle", rel, e.cyc);
        end
        hs_cnt++;
      end
      if (done_a) begin
        done_cnt++;
        chk("done_after_all_beats", hs_cnt, 8);
        if (exp_done >= 0) chk("done_cycle", rel, exp_done);
      end
      prev_stall = valid_a && !ready_a;
      prev_beat  = {eop_a, sop_a, data_a};
    end else begin
      prev_stall = 1'b0;
    end
  end

  int start_b_cyc = 0, hs_b = 0, done_b_cnt = 0;
  bit mon_b = 1'b0;

  // Monitor for DUT B (single-pixel frame).
  always @(negedge clk) begin
    int rel;
    if (!rst_b && mon_b) begin
      rel = cyc - start_b_cyc;
      if (rd_en_b) chk("b_rd_addr", int'(addr_b), 0);
      if (valid_b && ready_b) begin
        chk("b_beat", int'({eop_b, sop_b, data_b}), int'({2'b11, mem_b0}));
        chk("b_beat_cycle", rel, 3);
        hs_b++;
      end
      if (done_b) begin
        chk("b_done_cycle", rel, 4);
        done_b_cnt++;
      end
    end
  end

  // Reference model: pixel i of an N-pixel frame is mem[i], SOP iff i==0,
  // EOP iff i==N-1; with ready always high beat i lands in cycle 3+i.
  task automatic start_a_frame(input int m, input bit busy_chk, input int done_rel);
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      e.beat = {(i == 7), (i == 0), mem_a[i]};
      e.cyc  = (m == 0) ? 3 + i : -1;
      exp_q.push_back(e);
    end
    hs_cnt = 0; done_cnt = 0; rd_idx = 0; rd_early = 0;
    chk_busy = busy_chk; exp_done = done_rel;
    @(posedge clk); #1;
    mode = m; start_cyc = cyc; start_a = 1'b1; mon_en = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input string name);
    for (int k = 0; k < 400 && done_cnt < 1; k++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk({name, "_done_pulses"}, done_cnt, 1);
    chk({name, "_handshakes"}, hs_cnt, 8);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    ready_a = 1'b1; ready_b = 1'b1; rdata_a = 8'd0; rdata_b = 8'd0;
    for (int i = 0; i < 8; i++) mem_a[i] = 8'h10 + 8'(i);
    mem_b0 = 8'(($urandom % 255) + 1);

    repeat (3) @(negedge clk);
    chk("rst_valid_a", int'(valid_a), 0);
    chk("rst_sop_eop_a", int'({sop_a, eop_a}), 0);
    chk("rst_data_a", int'(data_a), 0);
    chk("rst_busy_done_a", int'({busy_a, done_a}), 0);
    chk("rst_rd_a", int'({rd_en_a, addr_a}), 0);
    chk("rst_outputs_b", int'({valid_b, busy_b, done_b, rd_en_b}), 0);
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (2) @(posedge clk);

    // 1: ready high, cycle-accurate beats, busy window and done
    start_a_frame(0, 1'b1, 11);
    wait_done_a("t1");

    // 2: alternating ready
    start_a_frame(1, 1'b0, -1);
    wait_done_a("t2");

    // 3: ready low until cycle 21
    start_a_frame(2, 1'b0, -1);
    wait_done_a("t3");
    chk("t3_reads_before_c21", rd_early, 4);

    // 4: single-pixel frame
    @(posedge clk); #1;
    start_b_cyc = cyc; start_b = 1'b1; mon_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    repeat (12) @(negedge clk);
    chk("t4_beats", hs_b, 1);
    chk("t4_done_pulses", done_b_cnt, 1);
    chk("t4_idle_after", int'({busy_b, valid_b}), 0);

    // 5: reset mid-frame after 3 accepted beats
    start_a_frame(0, 1'b0, 11);
    for (int k = 0; k < 100 && hs_cnt < 3; k++) @(negedge clk);
    chk("t5_beats_before_reset", hs_cnt, 3);
    @(posedge clk); #2;
    rst_a = 1'b1;
    #1;
    chk("t5_rst_valid", int'(valid_a), 0);
    chk("t5_rst_sop_eop", int'({sop_a, eop_a}), 0);
    chk("t5_rst_busy", int'(busy_a), 0);
    chk("t5_rst_rd_en", int'(rd_en_a), 0);
    mon_en = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst_a = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_no_resume_valid", int'(valid_a), 0);
    chk("t5_no_resume_busy", int'({busy_a, rd_en_a}), 0);
    start_a_frame(0, 1'b1, 11);
    wait_done_a("t5");

    // 6: start pulses in cycle 5 (streaming) and 11 (DONE) are ignored
    start_a_frame(0, 1'b1, 11);
    while (cyc - start_cyc < 5) begin @(posedge clk); #1; end
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    while (cyc - start_cyc < 11) begin @(posedge clk); #1; end
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    @(negedge clk);
    chk("t6_rel_cycle", cyc - start_cyc, 12);
    chk("t6_state_idle_c12", int'(dut_a.state_q), int'(IDLE));
    chk("t6_busy_low_c12", int'(busy_a), 0);
    repeat (30) @(negedge clk);
    chk("t6_handshakes", hs_cnt, 8);
    chk("t6_done_pulses", done_cnt, 1);
    chk("t6_no_second_read", rd_idx, 8);

    // 7: random pixels with random backpressure
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 8; i++) mem_a[i] = 8'($urandom);
      start_a_frame(3, 1'b0, -1);
      wait_done_a("t7");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/avalon_st_frame_source.md
Name: avalon_st_frame_source

Overview:
- Avalon-ST transmitter that streams one stored grayscale frame as a single packet, one 8-bit pixel per beat, with SOP on the first pixel and EOP on the last.
- Reads pixels from a synchronous frame-buffer read port and honours `aso_source1_ready` backpressure (ready latency 0).
- Feeds the Sobel filter's Avalon-ST sink, and also serves as the bench/SoC-side stimulus source.

Parameters:
- IMG_X_SIZE, 320, pixels per line
- IMG_Y_SIZE, 240, lines per frame
- ADDR_W, 17, frame-buffer address width; must satisfy 2^ADDR_W >= IMG_X_SIZE*IMG_Y_SIZE

Ports:
- csi_clkrst_clk  in  1  single clock; all logic is rising-edge
- csi_clkrst_reset  in  1  asynchronous, active-high reset
- start_i  in  1  one-cycle pulse; begins a frame when the block is idle
- busy_o  out  1  high from the cycle after an accepted start until the EOP beat is accepted
- done_o  out  1  one-cycle pulse in the cycle after the EOP beat is accepted
- mem_rd_en_o  out  1  frame-buffer read strobe
- mem_rd_addr_o  out  ADDR_W  pixel address, 0 .. N-1, where N = IMG_X_SIZE*IMG_Y_SIZE
- mem_rd_data_i  in  8  read data, valid exactly 1 cycle after mem_rd_en_o
- aso_source1_ready  in  1  sink ready
- aso_source1_data  out  8  pixel
- aso_source1_startofpacket  out  1  high on pixel 0
- aso_source1_endofpacket  out  1  high on pixel N-1
- aso_source1_valid  out  1  beat valid

Behaviour:
- Reset (async, active-high):
  - state = IDLE; address counter, in-flight flag and FIFO cleared.
  - All outputs are 0 while reset is asserted, including immediately mid-frame.
  - No partial packet resumes after reset.
- State machine:
  - IDLE: start_i=1 -> STREAM. start_i is ignored in every other state.
  - STREAM: issue reads; after address N-1 has been issued -> DRAIN.
  - DRAIN: no reads; on the EOP handshake (valid & ready & eop) -> DONE.
  - DONE: one cycle, done_o=1 -> IDLE.
- busy_o = (state is STREAM or DRAIN). It is low in IDLE and DONE.
- Read issue rule:
  - mem_rd_en_o=1 in STREAM when (fifo_count + inflight) < 4.
  - fifo_count is the value before any same-cycle pop.
  - inflight = 1 if a read was issued in the previous cycle.
  - mem_rd_addr_o increments by 1 per issued read, from 0 to N-1, with no wrap.
- Read-data capture: mem_rd_data_i is written to the FIFO in the cycle after the read, together with tags sop=(addr==0) and eop=(addr==N-1), both registered with the read.
- Output FIFO:
  - 4 entries of {eop, sop, data[7:0]}.
  - aso_source1_valid = FIFO not empty.
  - data, sop and eop come from the FIFO head.
  - Pop on valid & ready. A same-cycle push and pop is legal; the count is unchanged.
  - The issue rule guarantees no overflow. Push when full is a design error and is asserted in simulation.
- Avalon-ST rules:
  - Once valid is high, data, sop and eop stay stable until accepted.
  - valid never drops without a handshake, except on reset.
  - Ready latency is 0.
- Latency: start_i high in cycle 0 -> rd_en with addr 0 in cycle 1 -> FIFO push at end of cycle 2 -> valid first high in cycle 3.
- Throughput: with ready held high, one beat per cycle from cycle 3 to cycle N+2, with no bubbles.
- Boundary cases:
  - N=1: SOP and EOP on the same beat.
  - ready low indefinitely: at most 4 reads outstanding; rd_en stays low until a pop.
  - start_i asserted in the DONE cycle: ignored.

Decomposition:
- Shared package `sobel_pkg`:
  - IMG_X_SIZE/IMG_Y_SIZE defaults
  - PIX_W=8
  - N_PIX
  - state encoding localparams IDLE/STREAM/DRAIN/DONE (2-bit)
- Sub-module `st_skid_fifo`:
  - 4-deep synchronous FIFO, width 10, async active-high reset.
  - Outputs: count, empty, full.
  - Reused later on the Sobel output side.

Test Plan:
1. IMG 4x2, memory holds pixel i = 8'h10+i, ready=1, start in cycle 0:
   - Beats 8'h10..8'h17 are emitted in cycles 3..10.
   - SOP in cycle 3, EOP in cycle 10, done_o in cycle 11.
   - busy_o is high in cycles 1..10.
2. IMG 4x2, ready toggling 1,0,1,0…:
   - Sequence 8'h10..8'h17 arrives in order with no duplicates.
   - data, sop and eop are stable in every valid&!ready cycle.
   - Exactly 8 handshakes, then one done_o pulse.
3. IMG 4x2, ready=0 for cycles 0..20, then 1:
   - mem_rd_en_o is high in exactly 4 cycles (addresses 0..3) before cycle 21.
   - valid is high from cycle 3.
   - All 8 beats follow in order.
4. IMG 1x1, ready=1:
   - A single beat in cycle 3 with SOP=EOP=1, data = mem[0].
   - done_o in cycle 4.
5. IMG 4x2, reset asserted mid-cycle after 3 accepted beats:
   - valid, sop, eop and busy go 0 immediately.
   - After release plus a new start, the first beat is 8'h10 with SOP.
6. IMG 4x2, start_i pulsed again in cycles 5 and 11 (DONE):
   - Both pulses are ignored: exactly one packet and one done_o.
   - The FSM is in IDLE in cycle 12.
